// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
//   Shared definitions for the parity stream checker slice:
//   - state_t and its encodings IDLE / SHIFT / DONE
//   - parity mode constants PARITY_EVEN / PARITY_ODD
//   - clog2() used to size the serial bit counter
// ---------------------------------------------------------------------------
package parity_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t SHIFT = 2'd1;
   localparam state_t DONE  = 2'd2;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned v;
      int unsigned r;
      v = n - 1;
      r = 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/parity_stream_checker_if.sv
// ---------------------------------------------------------------------------
// parity_stream_checker_if
//   Bundles the input handshake, output handshake and error status of the
//   parity stream checker.
//   master : upstream/consumer side (drives in_*, odd_mode, out_ready,
//            clear_err)
//   slave  : the checker (drives in_ready, out_*, err_count, err_sticky)
// ---------------------------------------------------------------------------
interface parity_stream_checker_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 8
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_parity;
   logic                  odd_mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_parity;
   logic                  out_error;
   logic [CNT_WIDTH-1:0]  err_count;
   logic                  err_sticky;
   logic                  clear_err;

   modport master (
      output in_valid, in_data, in_parity, odd_mode, out_ready, clear_err,
      input  in_ready, out_valid, out_data, out_parity, out_error,
             err_count, err_sticky
   );

   modport slave (
      input  in_valid, in_data, in_parity, odd_mode, out_ready, clear_err,
      output in_ready, out_valid, out_data, out_parity, out_error,
             err_count, err_sticky
   );

endinterface

// File: rtl/parity_err_counter.sv
// ---------------------------------------------------------------------------
// parity_err_counter
//   Saturating error counter with sticky flag.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count one errored result
//   clear      : zero count and sticky; wins over a coincident inc
//   count      : saturating count, holds at all-ones
//   sticky     : set by any inc, cleared only by clear or reset
// ---------------------------------------------------------------------------
module parity_err_counter #(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   input  logic                 clear,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 sticky
);

   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 sticky_q, sticky_d;

   always_comb begin
      count_d  = count_q;
      sticky_d = sticky_q;
      if (clear) begin
         count_d  = '0;
         sticky_d = 1'b0;
      end else if (inc) begin
         sticky_d = 1'b1;
         if (count_q != '1) begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         sticky_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         sticky_q <= sticky_d;
      end
   end

   assign count  = count_q;
   assign sticky = sticky_q;

endmodule

// File: rtl/parity_stream_checker.sv
// ---------------------------------------------------------------------------
// parity_stream_checker
//   Accepts a DATA_WIDTH word plus received parity, computes the expected
//   parity (even/odd selected per word), flags a mismatch and keeps a
//   saturating error count.
//   clk, reset : clock, synchronous active-high reset
//   bus        : parity_stream_checker_if.slave (input/output handshakes,
//                clear_err, err_count, err_sticky)
//   Build option PARITY_STREAM_FAST_EN: parity is reduced in one cycle at
//   accept and the SHIFT state is skipped; otherwise bit-serial.
// ---------------------------------------------------------------------------
module parity_stream_checker
   import parity_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   parity_stream_checker_if.slave bus
);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_parity_q, out_parity_d;
   logic                  out_error_q, out_error_d;
   logic                  accept;
   logic                  err_inc;
   logic [CNT_WIDTH-1:0]  err_count;
   logic                  err_sticky;

`ifndef PARITY_STREAM_FAST_EN
   localparam int unsigned BCW = clog2(DATA_WIDTH);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic                  acc_q, acc_d;
   logic [BCW-1:0]        bitcnt_q, bitcnt_d;
   logic                  par_lat_q, par_lat_d;
   logic                  odd_q, odd_d;
   logic                  acc_next;
`endif

   assign accept = bus.in_valid && (state_q == IDLE);

   always_comb begin
      state_d      = state_q;
      out_data_d   = out_data_q;
      out_parity_d = out_parity_q;
      out_error_d  = out_error_q;
`ifndef PARITY_STREAM_FAST_EN
      sh_d         = sh_q;
      acc_d        = acc_q;
      bitcnt_d     = bitcnt_q;
      par_lat_d    = par_lat_q;
      odd_d        = odd_q;
      acc_next     = acc_q ^ sh_q[0];
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               out_data_d = bus.in_data;
`ifdef PARITY_STREAM_FAST_EN
               out_parity_d = (^bus.in_data) ^ (bus.odd_mode == PARITY_ODD);
               out_error_d  = out_parity_d ^ bus.in_parity;
               state_d      = DONE;
`else
               sh_d      = bus.in_data;
               acc_d     = 1'b0;
               bitcnt_d  = '0;
               par_lat_d = bus.in_parity;
               odd_d     = bus.odd_mode;
               state_d   = SHIFT;
`endif
            end
         end
`ifndef PARITY_STREAM_FAST_EN
         SHIFT: begin
            acc_d    = acc_next;
            sh_d     = sh_q >> 1;
            bitcnt_d = bitcnt_q + 1'b1;
            // Final bit folds in combinationally so the result lands in
            // DONE exactly DATA_WIDTH cycles after accept.
            if (bitcnt_q == LAST_BIT) begin
               out_parity_d = acc_next ^ (odd_q == PARITY_ODD);
               out_error_d  = out_parity_d ^ par_lat_q;
               state_d      = DONE;
            end
         end
`endif
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         out_data_q   <= '0;
         out_parity_q <= 1'b0;
         out_error_q  <= 1'b0;
`ifndef PARITY_STREAM_FAST_EN
         sh_q         <= '0;
         acc_q        <= 1'b0;
         bitcnt_q     <= '0;
         par_lat_q    <= 1'b0;
         odd_q        <= PARITY_EVEN;
`endif
      end else begin
         state_q      <= state_d;
         out_data_q   <= out_data_d;
         out_parity_q <= out_parity_d;
         out_error_q  <= out_error_d;
`ifndef PARITY_STREAM_FAST_EN
         sh_q         <= sh_d;
         acc_q        <= acc_d;
         bitcnt_q     <= bitcnt_d;
         par_lat_q    <= par_lat_d;
         odd_q        <= odd_d;
`endif
      end
   end

   assign err_inc = (state_q == DONE) && bus.out_ready && out_error_q;

   parity_err_counter #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_err_counter (
      .clk    (clk),
      .reset  (reset),
      .inc    (err_inc),
      .clear  (bus.clear_err),
      .count  (err_count),
      .sticky (err_sticky)
   );

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.out_data   = out_data_q;
   assign bus.out_parity = out_parity_q;
   assign bus.out_error  = out_error_q;
   assign bus.err_count  = err_count;
   assign bus.err_sticky = err_sticky;

endmodule

// File: tb/tb_parity_stream_checker.sv
module tb_parity_stream_checker;
   import parity_pkg::*;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 2;
`ifdef PARITY_STREAM_FAST_EN
   localparam int EXP_LAT = 1;
`else
   localparam int EXP_LAT = DW + 1;
`endif
   localparam int EXP_PERIOD = EXP_LAT + 1;

   typedef struct {
      logic [DW-1:0] d;
      logic          p;
      logic          e;
   } exp_t;

   logic clk;
   logic reset;
   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   logic [CW-1:0] exp_cnt;
   time accept_t;

   parity_stream_checker_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   parity_stream_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic model_parity(input logic [DW-1:0] d, input logic odd);
      int unsigned ones;
      ones = 0;
      for (int unsigned i = 0; i < DW; i++) if (d[i]) ones++;
      return ((ones % 2) == 1) ^ odd;
   endfunction

   task automatic drive_accept(input logic [DW-1:0] d, input logic p, input logic o,
                               output bit ok);
      exp_t e;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) ok = 1'b1;
      end
      if (ok) begin
         bus.in_data   = d;
         bus.in_parity = p;
         bus.odd_mode  = o;
         bus.in_valid  = 1'b1;
         e.d = d;
         e.p = model_parity(d, o);
         e.e = e.p ^ p;
         sb.push_back(e);
         @(posedge clk);
         accept_t = $time;
         #1;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_parity, bus.out_error, bus.err_sticky} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags: got rdy=%b vld=%b par=%b err=%b sticky=%b, expected 1 0 0 0 0",
                  bus.in_ready, bus.out_valid, bus.out_parity, bus.out_error, bus.err_sticky);
      end
      checks++;
      if (bus.out_data !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 00", bus.out_data);
      end
      checks++;
      if (bus.err_count !== '0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", bus.err_count);
      end
      exp_cnt = '0;
   endtask

   task automatic test_even();
      bit ok;
      int lat;
      exp_t e;
      bus.out_ready = 1'b1;
      drive_accept(8'hA5, 1'b0, PARITY_EVEN, ok);
      bus.in_data = 8'h5A;
      wait_valid(lat);
      checks++;
      if (!ok || lat != EXP_LAT) begin
         errors++;
         $display("FAIL even_latency: accepted=%0d latency=%0d expected %0d", ok, lat, EXP_LAT);
      end
      e = sb.pop_front();
      checks++;
      if (bus.out_data !== e.d || bus.out_parity !== e.p || bus.out_error !== e.e) begin
         errors++;
         $display("FAIL even_result: got d=%h p=%b e=%b expected d=%h p=%b e=%b",
                  bus.out_data, bus.out_parity, bus.out_error, e.d, e.p, e.e);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.err_count !== exp_cnt) begin
         errors++;
         $display("FAIL even_after: got vld=%b rdy=%b cnt=%0d expected 0 1 %0d",
                  bus.out_valid, bus.in_ready, bus.err_count, exp_cnt);
      end
   endtask

   task automatic test_odd_error();
      bit ok;
      int lat;
      exp_t e;
      drive_accept(8'hA5, 1'b0, PARITY_ODD, ok);
      wait_valid(lat);
      checks++;
      if (!ok || lat != EXP_LAT) begin
         errors++;
         $display("FAIL odd_latency: accepted=%0d latency=%0d expected %0d", ok, lat, EXP_LAT);
      end
      e = sb.pop_front();
      checks++;
      if (bus.out_data !== e.d || bus.out_parity !== e.p || bus.out_error !== e.e) begin
         errors++;
         $display("FAIL odd_result: got d=%h p=%b e=%b expected d=%h p=%b e=%b",
                  bus.out_data, bus.out_parity, bus.out_error, e.d, e.p, e.e);
      end
      checks++;
      if (bus.err_count !== exp_cnt) begin
         errors++;
         $display("FAIL odd_count_before: got %0d expected %0d", bus.err_count, exp_cnt);
      end
      handshake();
      if (e.e && exp_cnt != '1) exp_cnt++;
      checks++;
      if (bus.err_count !== exp_cnt || bus.err_sticky !== 1'b1) begin
         errors++;
         $display("FAIL odd_count_after: got cnt=%0d sticky=%b expected %0d 1",
                  bus.err_count, bus.err_sticky, exp_cnt);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      exp_t e;
      drive_accept(8'h01, 1'b1, PARITY_EVEN, ok);
      bus.in_data = 8'hFE;
      wait_valid(lat);
      checks++;
      if (!ok || lat != EXP_LAT) begin
         errors++;
         $display("FAIL bp_latency: accepted=%0d latency=%0d expected %0d", ok, lat, EXP_LAT);
      end
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== e.d ||
             bus.out_parity !== e.p || bus.out_error !== e.e) begin
            errors++;
            $display("FAIL bp_hold_%0d: got vld=%b rdy=%b d=%h p=%b e=%b expected 1 0 %h %b %b",
                     i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_parity, bus.out_error,
                     e.d, e.p, e.e);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = 8'h3C;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      handshake();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.err_count !== exp_cnt) begin
         errors++;
         $display("FAIL bp_release: got rdy=%b vld=%b cnt=%0d expected 1 0 %0d",
                  bus.in_ready, bus.out_valid, bus.err_count, exp_cnt);
      end
   endtask

   task automatic test_saturate();
      bit ok;
      int lat;
      exp_t e;
      logic [DW-1:0] d;
      bus.clear_err = 1'b1;
      @(posedge clk);
      #1;
      bus.clear_err = 1'b0;
      exp_cnt = '0;
      checks++;
      if (bus.err_count !== '0 || bus.err_sticky !== 1'b0) begin
         errors++;
         $display("FAIL clear_alone: got cnt=%0d sticky=%b expected 0 0", bus.err_count, bus.err_sticky);
      end
      for (int k = 0; k < 5; k++) begin
         d = 8'h03 << k;
         drive_accept(d, 1'b1, PARITY_EVEN, ok);
         wait_valid(lat);
         e = sb.pop_front();
         checks++;
         if (!ok || lat != EXP_LAT || bus.out_parity !== e.p || bus.out_error !== e.e) begin
            errors++;
            $display("FAIL sat_result_%0d: ok=%0d lat=%0d p=%b e=%b expected lat %0d p=%b e=%b",
                     k, ok, lat, bus.out_parity, bus.out_error, EXP_LAT, e.p, e.e);
         end
         handshake();
         if (e.e && exp_cnt != '1) exp_cnt++;
         checks++;
         if (bus.err_count !== exp_cnt || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sat_count_%0d: got cnt=%0d sticky=%b expected %0d 1",
                     k, bus.err_count, bus.err_sticky, exp_cnt);
         end
      end
      drive_accept(8'hC0, 1'b0, PARITY_ODD, ok);
      wait_valid(lat);
      e = sb.pop_front();
      checks++;
      if (!ok || bus.out_valid !== 1'b1 || bus.out_error !== e.e) begin
         errors++;
         $display("FAIL clear_coinc_result: ok=%0d vld=%b e=%b expected 1 1 %b",
                  ok, bus.out_valid, bus.out_error, e.e);
      end
      bus.clear_err = 1'b1;
      handshake();
      bus.clear_err = 1'b0;
      exp_cnt = '0;
      checks++;
      if (bus.err_count !== '0 || bus.err_sticky !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL clear_coinc: got cnt=%0d sticky=%b rdy=%b expected 0 0 1",
                  bus.err_count, bus.err_sticky, bus.in_ready);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int lat;
      exp_t e;
      drive_accept(8'hFF, 1'b1, PARITY_EVEN, ok);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      if (sb.size() > 0) void'(sb.pop_back());
      checks++;
      if (!ok || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
          bus.out_error !== 1'b0 || bus.err_count !== '0 || bus.err_sticky !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: ok=%0d rdy=%b vld=%b d=%h e=%b cnt=%0d sticky=%b expected 1 1 0 00 0 0 0",
                  ok, bus.in_ready, bus.out_valid, bus.out_data, bus.out_error,
                  bus.err_count, bus.err_sticky);
      end
      exp_cnt = '0;
      drive_accept(8'h00, 1'b0, PARITY_EVEN, ok);
      wait_valid(lat);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != EXP_LAT || bus.out_data !== e.d || bus.out_parity !== e.p ||
          bus.out_error !== e.e) begin
         errors++;
         $display("FAIL reset_mid_next: ok=%0d lat=%0d d=%h p=%b e=%b expected lat %0d d=%h p=%b e=%b",
                  ok, lat, bus.out_data, bus.out_parity, bus.out_error, EXP_LAT, e.d, e.p, e.e);
      end
      handshake();
   endtask

   task automatic test_odd_vector();
      bit ok;
      int lat;
      exp_t e;
      drive_accept(8'h7F, 1'b0, PARITY_ODD, ok);
      wait_valid(lat);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != EXP_LAT || bus.out_parity !== e.p || bus.out_error !== e.e) begin
         errors++;
         $display("FAIL odd_7f: ok=%0d lat=%0d p=%b e=%b expected lat %0d p=%b e=%b",
                  ok, lat, bus.out_parity, bus.out_error, EXP_LAT, e.p, e.e);
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2;
      int lat;
      exp_t e;
      time t1;
      bus.out_ready = 1'b1;
      drive_accept(8'h81, 1'b1, PARITY_ODD, ok1);
      t1 = accept_t;
      wait_valid(lat);
      e = sb.pop_front();
      checks++;
      if (!ok1 || bus.out_data !== e.d || bus.out_parity !== e.p || bus.out_error !== e.e) begin
         errors++;
         $display("FAIL b2b_first: ok=%0d d=%h p=%b e=%b expected d=%h p=%b e=%b",
                  ok1, bus.out_data, bus.out_parity, bus.out_error, e.d, e.p, e.e);
      end
      drive_accept(8'h80, 1'b1, PARITY_EVEN, ok2);
      checks++;
      if (!ok2 || (accept_t - t1) != EXP_PERIOD * 10) begin
         errors++;
         $display("FAIL b2b_period: ok=%0d got %0t expected %0d cycles", ok2, accept_t - t1, EXP_PERIOD);
      end
      wait_valid(lat);
      e = sb.pop_front();
      checks++;
      if (bus.out_data !== e.d || bus.out_parity !== e.p || bus.out_error !== e.e) begin
         errors++;
         $display("FAIL b2b_second: d=%h p=%b e=%b expected d=%h p=%b e=%b",
                  bus.out_data, bus.out_parity, bus.out_error, e.d, e.p, e.e);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checks++;
      if (sb.size() != 0 || bus.err_count !== exp_cnt) begin
         errors++;
         $display("FAIL b2b_end: queue=%0d cnt=%0d expected 0 %0d", sb.size(), bus.err_count, exp_cnt);
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_parity = 1'b0;
      bus.odd_mode  = PARITY_EVEN;
      bus.out_ready = 1'b0;
      bus.clear_err = 1'b0;
      exp_cnt       = '0;
      accept_t      = 0;
      test_reset();
      test_even();
      test_odd_error();
      test_backpressure();
      test_saturate();
      test_reset_mid();
      test_odd_vector();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/parity_stream_checker.md
Name: parity_stream_checker

Overview:
- Parametrised, handshaked successor to the 8-bit combinational parity checker.
- Accepts one DATA_WIDTH-bit word plus its received parity bit, and computes the expected parity bit-serially, one bit per clock.
- Parity mode (even or odd) is selected per word. The block flags a mismatch and keeps a saturating error count.
- Sits between a receive deserialiser (e.g. UART RX) and the consumer of checked bytes.

Parameters:
- DATA_WIDTH, 8, word width in bits; must be >= 2.
- CNT_WIDTH, 8, width of the saturating error counter; must be >= 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  word and parity on in_data/in_parity/odd_mode are valid.
- in_ready  output  1  block can accept a word.
- in_data  input  DATA_WIDTH  word to check.
- in_parity  input  1  received parity bit.
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled at accept.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- out_data  output  DATA_WIDTH  the accepted word, passed through.
- out_parity  output  1  expected parity bit.
- out_error  output  1  in_parity != out_parity.
- err_count  output  CNT_WIDTH  saturating count of errored results.
- err_sticky  output  1  set by any errored result; cleared only by clear_err or reset.
- clear_err  input  1  synchronous clear of err_count and err_sticky.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state IDLE; in_ready=1; out_valid=0; out_data=0; out_parity=0; out_error=0; err_count=0; err_sticky=0.
- State IDLE:
  - in_ready=1.
  - Accept occurs on in_valid & in_ready.
  - On accept: latch in_data into shift register and into out_data; latch in_parity and odd_mode; clear the accumulator and bit counter; go to SHIFT.
- State SHIFT:
  - in_ready=0.
  - Each cycle: acc ^= sh[0]; sh >>= 1; bitcnt++.
  - After DATA_WIDTH SHIFT cycles: register out_parity = acc ^ odd_mode_latched and out_error = out_parity ^ in_parity_latched; go to DONE.
- State DONE:
  - out_valid=1. out_data, out_parity and out_error are held stable until out_ready.
  - On out_valid & out_ready: go to IDLE.
- Latency and throughput:
  - out_valid rises DATA_WIDTH+1 clocks after the accept edge.
  - in_ready returns the cycle after the output handshake.
  - Maximum throughput is one word per DATA_WIDTH+2 cycles; there is no back-to-back accept.
- Parity definition:
  - Even mode: out_parity = XOR of all bits, so data plus parity has an even number of 1s.
  - Odd mode: out_parity is the complement of that.
- Error counter:
  - Increments by 1 on an output handshake with out_error=1.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - err_sticky is set on the same event.
- clear_err:
  - Zeroes err_count and err_sticky next edge.
  - If it coincides with an errored handshake, clear wins: result is count 0, sticky 0.
  - It does not affect the datapath FSM.
- Ignored inputs:
  - in_valid while in_ready=0 is ignored; the upstream must hold.
  - in_data changes during SHIFT have no effect.
- Reset mid-operation: in SHIFT or DONE, the in-flight word is discarded and all outputs return to their reset values.
- out_ready outside DONE is ignored.

Optional Feature:
- Macro: PARITY_STREAM_FAST_EN.
- When defined:
  - The SHIFT state is removed.
  - Parity is the full XOR reduction of in_data, computed at accept.
  - The result is registered directly into DONE, so out_valid rises 1 clock after accept.
- When undefined: bit-serial behaviour as above.
- Handshake, counter and clear rules are identical in both builds.

Decomposition:
- Shared package parity_pkg:
  - state typedef (IDLE, SHIFT, DONE);
  - mode constants PARITY_EVEN=0 and PARITY_ODD=1;
  - bit-counter width function clog2(DATA_WIDTH).
- Sub-module: parity_err_counter, a saturating CNT_WIDTH counter with increment, clear (clear priority) and sticky flag. It is instantiated once.

Test Plan:
- Even mode, in_data=8'hA5, in_parity=0, out_ready=1 -> out_valid 9 cycles after accept; out_parity=0, out_error=0, err_count=0.
- Odd mode, in_data=8'hA5, in_parity=0 -> out_parity=1, out_error=1; err_count=1 and err_sticky=1 after the handshake.
- Backpressure, 8'h01 even, out_ready low for 5 cycles in DONE -> out_valid, out_data=8'h01 and out_parity=1 held stable; in_ready=0 throughout; accept resumes 1 cycle after the handshake.
- CNT_WIDTH=2, 5 consecutive errored words -> err_count sequence 1,2,3,3,3. Then clear_err coincident with a 6th errored handshake -> err_count=0, err_sticky=0.
- Reset asserted on the 4th SHIFT cycle of 8'hFF -> next cycle: IDLE, in_ready=1, out_valid=0; no count change. The following word 8'h00 even gives out_parity=0.
- PARITY_STREAM_FAST_EN build, 8'h7F odd, in_parity=0 -> out_valid 1 cycle after accept; out_parity=0, out_error=0.
